// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_pkg
//  Description : Shared types and constants for the pipeline stall/flush
//                controller: D-cache miss FSM state encoding, default
//                register-index width and the x0 register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    localparam int C_X0_IDX   = 0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Purely combinational load-use and taken-branch detection.
//                Load-use wins over the branch flush because the branch
//                operands are not yet available.
//  Ports       : i_id_rs1 / i_id_rs2   - source registers of the ID instruction
//                i_ex_memread / i_ex_rd - load flag and destination in EX
//                i_branch_taken        - branch in ID resolved taken
//                o_lu                  - load-use hazard detected
//                o_flush               - IF/ID flush request
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] i_id_rs1,
    input  logic [ADDR_W-1:0] i_id_rs2,
    input  logic              i_ex_memread,
    input  logic [ADDR_W-1:0] i_ex_rd,
    input  logic              i_branch_taken,
    output logic              o_lu,
    output logic              o_flush
);
    import pipeline_hazard_ctrl_pkg::*;

    logic w_rd_nonzero;
    logic w_rd_match;

    assign w_rd_nonzero = (i_ex_rd != ADDR_W'(C_X0_IDX));
    assign w_rd_match   = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);
    assign o_lu         = i_ex_memread & w_rd_nonzero & w_rd_match;
    assign o_flush      = i_branch_taken & ~o_lu;

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Central stall/flush controller for the 5-stage pipeline.
//                Combines load-use / branch hazard handling with a D-cache
//                miss FSM (write-back + refill handshake) that freezes the
//                whole pipeline, plus saturating stall and miss counters.
//  Ports       : clk_i, rst_i (sync, active-high)
//                id_rs1_i, id_rs2_i, ex_memread_i, ex_rd_i, id_branch_taken_i
//                dc_req_i, dc_hit_i, dc_dirty_i, mem_ack_i
//                pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
//                cpu_stall_o, mem_wr_req_o, mem_rd_req_o, dc_refill_o,
//                stall_cnt_o, miss_cnt_o
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  id_branch_taken_i,
    input  logic                  dc_req_i,
    input  logic                  dc_hit_i,
    input  logic                  dc_dirty_i,
    input  logic                  mem_ack_i,
    output logic                  pc_write_o,
    output logic                  ifid_stall_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic                  cpu_stall_o,
    output logic                  mem_wr_req_o,
    output logic                  mem_rd_req_o,
    output logic                  dc_refill_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      miss_cnt_o
);
    import pipeline_hazard_ctrl_pkg::*;

    logic             w_lu;
    logic             w_flush;
    logic             w_miss;
    logic             w_cpu_stall;

    state_t           r_state;
    logic             r_wr_req;
    logic             r_rd_req;
    logic             r_refill;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    hazard_detect #(
        .ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .i_id_rs1       (id_rs1_i),
        .i_id_rs2       (id_rs2_i),
        .i_ex_memread   (ex_memread_i),
        .i_ex_rd        (ex_rd_i),
        .i_branch_taken (id_branch_taken_i),
        .o_lu           (w_lu),
        .o_flush        (w_flush)
    );

    // A miss freezes the pipeline in the very cycle it is detected, so the
    // stall is combinational on the request/hit inputs as well as the state.
    assign w_miss      = dc_req_i & ~dc_hit_i;
    assign w_cpu_stall = (r_state != ST_IDLE) | w_miss;

    // The freeze masks all hazard actions; since nothing moves, the hazard is
    // simply re-detected once the freeze releases.
    assign cpu_stall_o   = w_cpu_stall;
    assign pc_write_o    = ~w_cpu_stall & ~w_lu;
    assign ifid_stall_o  = ~w_cpu_stall & w_lu;
    assign idex_bubble_o = ~w_cpu_stall & w_lu;
    assign ifid_flush_o  = ~w_cpu_stall & w_flush;

    assign mem_wr_req_o  = r_wr_req;
    assign mem_rd_req_o  = r_rd_req;
    assign dc_refill_o   = r_refill;
    assign stall_cnt_o   = r_stall_cnt;
    assign miss_cnt_o    = r_miss_cnt;

    // Miss FSM with request/strobe outputs registered alongside the state so
    // they always match the state they belong to.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_wr_req    <= 1'b0;
            r_rd_req    <= 1'b0;
            r_refill    <= 1'b0;
            r_stall_cnt <= '0;
            r_miss_cnt  <= '0;
        end else begin
            if (w_cpu_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        if (r_miss_cnt != '1) begin
                            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                        end
                        if (dc_dirty_i) begin
                            r_state  <= ST_WRITEBACK;
                            r_wr_req <= 1'b1;
                        end else begin
                            r_state  <= ST_REFILL;
                            r_rd_req <= 1'b1;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_state  <= ST_REFILL;
                        r_wr_req <= 1'b0;
                        r_rd_req <= 1'b1;
                    end
                end
                ST_REFILL: begin
                    if (mem_ack_i) begin
                        r_state  <= ST_DONE;
                        r_rd_req <= 1'b0;
                        r_refill <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_refill <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_wr_req <= 1'b0;
                    r_rd_req <= 1'b0;
                    r_refill <= 1'b0;
                end
            endcase
        end
    end

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Self-checking bench for pipeline_hazard_ctrl. Two instances
//                (16-bit and 4-bit counters) share all inputs; a cycle-level
//                reference model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_WB   = 1;
    localparam int M_RF   = 2;
    localparam int M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_memread, br_taken, dc_req, dc_hit, dc_dirty, mem_ack;

    logic        pc_write, ifid_stall, ifid_flush, idex_bubble, cpu_stall;
    logic        wr_req, rd_req, refill;
    logic [15:0] stall_cnt, miss_cnt;
    logic        pc_write4, ifid_stall4, ifid_flush4, idex_bubble4, cpu_stall4;
    logic        wr_req4, rd_req4, refill4;
    logic [3:0]  stall_cnt4, miss_cnt4;

    int total = 0;
    int bad   = 0;

    // reference model: which part of the miss transaction is outstanding,
    // and unbounded event counts (saturation applied when comparing)
    int m_phase;
    int m_stalls;
    int m_misses;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .ex_memread_i(ex_memread), .ex_rd_i(ex_rd), .id_branch_taken_i(br_taken),
        .dc_req_i(dc_req), .dc_hit_i(dc_hit), .dc_dirty_i(dc_dirty), .mem_ack_i(mem_ack),
        .pc_write_o(pc_write), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
        .idex_bubble_o(idex_bubble), .cpu_stall_o(cpu_stall), .mem_wr_req_o(wr_req),
        .mem_rd_req_o(rd_req), .dc_refill_o(refill), .stall_cnt_o(stall_cnt),
        .miss_cnt_o(miss_cnt)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .ex_memread_i(ex_memread), .ex_rd_i(ex_rd), .id_branch_taken_i(br_taken),
        .dc_req_i(dc_req), .dc_hit_i(dc_hit), .dc_dirty_i(dc_dirty), .mem_ack_i(mem_ack),
        .pc_write_o(pc_write4), .ifid_stall_o(ifid_stall4), .ifid_flush_o(ifid_flush4),
        .idex_bubble_o(idex_bubble4), .cpu_stall_o(cpu_stall4), .mem_wr_req_o(wr_req4),
        .mem_rd_req_o(rd_req4), .dc_refill_o(refill4), .stall_cnt_o(stall_cnt4),
        .miss_cnt_o(miss_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic check_all();
        bit lu, stall;
        lu    = ex_memread && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
        stall = (m_phase != M_IDLE) || (dc_req && !dc_hit);
        check("cpu_stall",   32'(cpu_stall),   32'(stall));
        check("pc_write",    32'(pc_write),    32'(!stall && !lu));
        check("ifid_stall",  32'(ifid_stall),  32'(!stall && lu));
        check("idex_bubble", 32'(idex_bubble), 32'(!stall && lu));
        check("ifid_flush",  32'(ifid_flush),  32'(!stall && br_taken && !lu));
        check("mem_wr_req",  32'(wr_req),      32'(m_phase == M_WB));
        check("mem_rd_req",  32'(rd_req),      32'(m_phase == M_RF));
        check("dc_refill",   32'(refill),      32'(m_phase == M_DONE));
        check("req_overlap", 32'(wr_req & rd_req), 32'(0));
        check("stall_cnt16", 32'(stall_cnt),   32'(sat(m_stalls, 65535)));
        check("miss_cnt16",  32'(miss_cnt),    32'(sat(m_misses, 65535)));
        check("stall_cnt4",  32'(stall_cnt4),  32'(sat(m_stalls, 15)));
        check("miss_cnt4",   32'(miss_cnt4),   32'(sat(m_misses, 15)));
        check("cpu_stall4",  32'(cpu_stall4),  32'(stall));
        check("mem_rd_req4", 32'(rd_req4),     32'(m_phase == M_RF));
    endtask

    task automatic model_step();
        if (rst) begin
            m_phase  = M_IDLE;
            m_stalls = 0;
            m_misses = 0;
        end else begin
            if ((m_phase != M_IDLE) || (dc_req && !dc_hit)) m_stalls++;
            case (m_phase)
                M_IDLE: if (dc_req && !dc_hit) begin
                    m_misses++;
                    m_phase = dc_dirty ? M_WB : M_RF;
                end
                M_WB:   if (mem_ack) m_phase = M_RF;
                M_RF:   if (mem_ack) m_phase = M_DONE;
                default: m_phase = M_IDLE;
            endcase
        end
    endtask

    // inputs are held for one full cycle: checked mid-cycle, model advanced
    // on the edge that consumes them
    task automatic do_cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit br, input bit req,
                         input bit hit, input bit dirty, input bit ack);
        ex_memread = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; br_taken = br;
        dc_req = req; dc_hit = hit; dc_dirty = dirty; mem_ack = ack;
        do_cycle();
    endtask

    initial begin
        m_phase = M_IDLE; m_stalls = 0; m_misses = 0;
        rst = 1'b1;
        ex_memread = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; br_taken = 0;
        dc_req = 0; dc_hit = 0; dc_dirty = 0; mem_ack = 0;

        // reset state
        do_cycle();
        do_cycle();
        rst = 1'b0;
        check("rst_pc_write", 32'(pc_write), 32'(1));
        check("rst_stall_cnt", 32'(stall_cnt), 32'(0));

        // load-use hazards and branch flushes
        drive(1, 5'd5, 5'd5, 5'd1, 0, 0, 0, 0, 0);
        check("lu_pc_write", 32'(pc_write), 32'(0));
        check("lu_bubble", 32'(idex_bubble), 32'(1));
        drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);   // rd = x0: no hazard
        drive(1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0, 0);   // match on rs2
        drive(0, 5'd7, 5'd7, 5'd7, 1, 0, 0, 0, 0);   // branch alone flushes
        check("br_flush", 32'(ifid_flush), 32'(1));
        drive(1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0, 0);   // lu beats the flush
        check("br_lu_flush", 32'(ifid_flush), 32'(0));
        drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, 0);   // hit: no stall

        // clean miss, ack on the 4th REFILL cycle, replay hits
        rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0); rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);            // detect
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1, 0, 0, i == 3);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1);            // DONE, ack ignored
        drive(0, 0, 0, 0, 0, 1, 1, 0, 0);            // replay hits
        check("clean_stall_cnt", 32'(stall_cnt), 32'(6));
        check("clean_miss_cnt", 32'(miss_cnt), 32'(1));

        // dirty miss with lu and taken branch held throughout
        drive(1, 5'd9, 5'd9, 5'd2, 1, 1, 0, 1, 0);
        for (int i = 0; i < 2; i++) drive(1, 5'd9, 5'd9, 5'd2, 1, 1, 0, 1, i == 1);
        for (int i = 0; i < 2; i++) drive(1, 5'd9, 5'd9, 5'd2, 1, 1, 0, 1, i == 1);
        drive(1, 5'd9, 5'd9, 5'd2, 1, 1, 0, 1, 0);   // DONE
        drive(1, 5'd9, 5'd9, 5'd2, 1, 1, 1, 0, 0);   // released: lu re-seen
        check("dirty_stall_cnt", 32'(stall_cnt), 32'(6 + 6));

        // reset in the middle of REFILL, then a spurious ack
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        rst = 1'b1; drive(0, 0, 0, 0, 0, 1, 0, 0, 0); rst = 1'b0;
        check("midrst_rd_req", 32'(rd_req), 32'(0));
        check("midrst_miss_cnt", 32'(miss_cnt), 32'(0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 19 stall cycles: 4-bit counter must stick at 15
        for (int i = 0; i < 19; i++) drive(0, 0, 0, 0, 0, 1, 0, 1, 0);
        check("sat_stall_cnt4", 32'(stall_cnt4), 32'(15));
        check("sat_stall_cnt16", 32'(stall_cnt), 32'(19));
        drive(0, 0, 0, 0, 0, 1, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 1, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 1, 1, 1, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0));
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives the IF/ID register's stall_i, Flush_i and cpu_stall_i, the PC write enable and the ID/EX bubble.
- Combinational side: load-use and taken-branch hazard detection.
- Sequential side: a D-cache miss FSM that freezes the whole pipeline and runs the write-back/refill handshake with main memory.
- Also keeps saturating stall and miss counters for performance measurement.

Parameters:
REG_ADDR_W, 5, register index width
CNT_W, 16, width of the stall-cycle and miss counters (both saturate)

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_i  in  1  synchronous, active-high reset
id_rs1_i  in  REG_ADDR_W  rs1 of the instruction in ID
id_rs2_i  in  REG_ADDR_W  rs2 of the instruction in ID
ex_memread_i  in  1  instruction in EX is a load
ex_rd_i  in  REG_ADDR_W  rd of the instruction in EX
id_branch_taken_i  in  1  branch in ID resolved taken
dc_req_i  in  1  MEM stage issues a D-cache access this cycle
dc_hit_i  in  1  D-cache tag hit for that access
dc_dirty_i  in  1  victim line is dirty
mem_ack_i  in  1  main memory completed the current request (one-cycle pulse)
pc_write_o  out  1  PC update enable
ifid_stall_o  out  1  IF/ID hold
ifid_flush_o  out  1  IF/ID flush (instruction zeroed)
idex_bubble_o  out  1  zero the control fields into ID/EX
cpu_stall_o  out  1  global freeze of all pipeline registers and PC
mem_wr_req_o  out  1  write-back request to memory
mem_rd_req_o  out  1  refill request to memory
dc_refill_o  out  1  one-cycle strobe: write the returned line into the D-cache
stall_cnt_o  out  CNT_W  cycles with cpu_stall_o=1
miss_cnt_o  out  CNT_W  number of D-cache misses started

Behaviour:
- Load-use hazard (lu):
  - lu = ex_memread_i & (ex_rd_i != 0) & ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i)).
  - When lu=1: pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1.
- Branch flush:
  - ifid_flush_o = id_branch_taken_i & ~lu.
  - lu has priority over flush because the branch operands are not ready yet.
- Global freeze: when cpu_stall_o=1, ifid_stall_o, ifid_flush_o and idex_bubble_o are forced to 0 and pc_write_o is forced to 0.
- Idle default: pc_write_o=1; all other hazard outputs are 0.
- FSM states: IDLE, WRITEBACK, REFILL, DONE.
  - IDLE: on dc_req_i & ~dc_hit_i, go to WRITEBACK if dc_dirty_i, else REFILL; miss_cnt_o increments. A hit or no request stays in IDLE. mem_ack_i is ignored in IDLE.
  - WRITEBACK: mem_wr_req_o=1 (Moore output). On mem_ack_i go to REFILL.
  - REFILL: mem_rd_req_o=1 (Moore output). On mem_ack_i go to DONE.
  - DONE: dc_refill_o=1 for exactly one cycle, then IDLE unconditionally.
  - mem_wr_req_o and mem_rd_req_o are never both 1.
- cpu_stall_o (combinational) = (state != IDLE) | (dc_req_i & ~dc_hit_i).
  - It rises in the miss-detect cycle with zero latency.
  - It falls in the first IDLE cycle after DONE, provided the replayed access hits.
- Minimum miss penalty:
  - Clean miss with ack in the first request cycle: 3 stall cycles (detect, REFILL, DONE).
  - Dirty miss: +1 cycle per extra ack wait.
- Counters:
  - stall_cnt_o increments every cycle cpu_stall_o=1.
  - Both counters saturate at all-ones and never wrap.
- Simultaneous events:
  - A miss in the same cycle as lu or a taken branch: the freeze wins and the hazard outputs are masked. The hazard is re-evaluated after the freeze releases because the pipeline contents are unchanged.
  - A mem_ack_i in DONE is ignored.
- Reset:
  - On a clock edge with rst_i=1, the FSM returns to IDLE and both counters clear to 0.
  - This holds mid-miss: mem_*_req_o and dc_refill_o are 0 from the cycle after the reset edge. Memory must tolerate an abandoned request.
  - Reset values: pc_write_o=1; all other outputs 0, subject to the combinational inputs in the cycle after reset.

Decomposition:
- Shared package holds:
  - the FSM state enum (2-bit: IDLE=0, WRITEBACK=1, REFILL=2, DONE=3);
  - REG_ADDR_W;
  - the x0 register index constant.
- Sub-module hazard_detect: purely combinational lu/flush logic, instantiated once.
- The FSM and the counters stay in the top module.

Test Plan:
- ex_memread=1, ex_rd=5, id_rs1=5, no miss -> pc_write=0, ifid_stall=1, idex_bubble=1, ifid_flush=0; with ex_rd=0 -> all hazard outputs 0.
- id_branch_taken=1, no lu -> ifid_flush=1 for 1 cycle. Same with lu active -> ifid_flush=0, ifid_stall=1.
- Clean miss (dc_req=1, hit=0, dirty=0), mem_ack after 4 REFILL cycles:
  - mem_rd_req high for 4 cycles, then dc_refill pulses once;
  - cpu_stall high 6 cycles total; stall_cnt=6, miss_cnt=1.
- Dirty miss, ack after 2 cycles in WRITEBACK and 2 in REFILL:
  - mem_wr_req high 2 cycles, then mem_rd_req high 2 cycles, never overlapping;
  - lu and a taken branch asserted throughout are fully masked.
- rst_i=1 while in REFILL -> next cycle state IDLE, mem_rd_req=0, counters 0; a spurious mem_ack afterwards causes no transition.
- Force 2^CNT_W+3 stall cycles (CNT_W=4 build) -> stall_cnt holds at 15 and does not wrap.
